// File: rtl/memory_stage_if.sv
// -----------------------------------------------------------------------------
// memory_stage_if
// Data-memory request/acknowledge bus between the beta memory stage and the
// data memory.
//   dmem_req    master -> slave  access request
//   dmem_we     master -> slave  1 = write (ST), 0 = read (LD/LDR)
//   dmem_addr   master -> slave  word-aligned byte address
//   dmem_wdata  master -> slave  store data
//   dmem_ack    slave  -> master access complete, sampled while dmem_req=1
//   dmem_rdata  slave  -> master read data, valid in the ack cycle
// -----------------------------------------------------------------------------
interface memory_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
// Memory stage of the beta pipeline. Latches pc/ir/y/st from execute, issues
// LD/LDR reads and ST writes over the dmem bus, stalls upstream while an access
// is outstanding and hands pc/ir/y/load data to writeback. A request left
// unacknowledged for TIMEOUT stall cycles turns into a memory-fault exception.
// Parameters:
//   TIMEOUT      stall cycles without ack before a fault; 0 = never time out
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   ir_src_mem   IR source for the instruction in this stage (DATA/NOP/EXCEPT)
//   pc_mem_next, ir_mem_next, y_mem_next, st_mem_next   next stage contents
//   dmem         data-memory bus (master side)
//   stall_mem    freeze upstream stage registers this cycle
//   mem_fault    one-cycle pulse on timeout
//   pc_wb_next, ir_wb_next, y_wb_next, ld_wb_next      values for writeback
// -----------------------------------------------------------------------------
module memory_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            ir_src_mem,
    input  logic [31:0]           pc_mem_next,
    input  logic [31:0]           ir_mem_next,
    input  logic [31:0]           y_mem_next,
    input  logic [31:0]           st_mem_next,
    memory_stage_if.master        dmem,
    output logic                  stall_mem,
    output logic                  mem_fault,
    output logic [31:0]           pc_wb_next,
    output logic [31:0]           ir_wb_next,
    output logic [31:0]           y_wb_next,
    output logic [31:0]           ld_wb_next
);
    localparam logic [1:0]  IR_SRC_DATA     = 2'd0;
    localparam logic [1:0]  IR_SRC_NOP      = 2'd1;
    localparam logic [1:0]  IR_SRC_EXCEPT   = 2'd2;
    // ADD(R31,R31,R31) and BNE(R31,0,XP)
    localparam logic [31:0] INST_NOP        = 32'h83FF_F800;
    localparam logic [31:0] INST_BNE_EXCEPT = 32'h77DF_0000;
    localparam logic [5:0]  OP_LD           = 6'h18;
    localparam logic [5:0]  OP_ST           = 6'h19;
    localparam logic [5:0]  OP_LDR          = 6'h1F;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FAULT} state_t;

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] pc_mem_q, ir_mem_q, y_mem_q, st_mem_q;
    logic [5:0]  opcode;
    logic        is_store;
    logic        mem_op;
    logic        req;

    // timer counts stall cycles of the current access, including this one
    function automatic logic timed_out(input logic [31:0] cnt);
        return (TIMEOUT != 0) && (cnt == TIMEOUT);
    endfunction

    assign opcode   = ir_mem_q[31:26];
    assign is_store = (opcode == OP_ST);
    assign mem_op   = (ir_src_mem == IR_SRC_DATA) &&
                      ((opcode == OP_LD) || is_store || (opcode == OP_LDR));

    // Stage registers: hold while stalled so addr/we/wdata stay stable in BUSY
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_mem_q <= '0;
            ir_mem_q <= INST_NOP;
            y_mem_q  <= '0;
            st_mem_q <= '0;
        end else if (!stall_mem) begin
            pc_mem_q <= pc_mem_next;
            ir_mem_q <= ir_mem_next;
            y_mem_q  <= y_mem_next;
            st_mem_q <= st_mem_next;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                if (mem_op && !dmem.dmem_ack) begin
                    timer_d = 32'd1;
                    state_d = timed_out(32'd1) ? S_FAULT : S_BUSY;
                end
            end
            S_BUSY: begin
                if (dmem.dmem_ack) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 32'd1;
                    if (timed_out(timer_d)) begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_FAULT: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // FSM outputs; dmem_ack feeds stall_mem and ir_wb_next combinationally
    always_comb begin
        req       = 1'b0;
        stall_mem = 1'b0;
        mem_fault = 1'b0;
        case (state_q)
            S_IDLE: begin
                req       = mem_op;
                stall_mem = mem_op && !dmem.dmem_ack;
            end
            S_BUSY: begin
                req       = 1'b1;
                stall_mem = !dmem.dmem_ack;
            end
            S_FAULT: begin
                mem_fault = 1'b1;
            end
            default: ;
        endcase

        if ((ir_src_mem == IR_SRC_EXCEPT) || mem_fault) begin
            ir_wb_next = INST_BNE_EXCEPT;
        end else if ((ir_src_mem == IR_SRC_NOP) || stall_mem) begin
            ir_wb_next = INST_NOP;
        end else begin
            ir_wb_next = ir_mem_q;
        end

        // An ack with req low (annulled op, FAULT cycle) carries no data
        ld_wb_next = (req && dmem.dmem_ack && !is_store) ? dmem.dmem_rdata : 32'd0;
    end

    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = is_store;
    assign dmem.dmem_addr  = {y_mem_q[31:2], 2'b00};
    assign dmem.dmem_wdata = st_mem_q;
    assign pc_wb_next      = pc_mem_q;
    assign y_wb_next       = y_mem_q;
endmodule

// File: tb/tb_memory_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_stage
// Acts as the execute stage and the data memory around memory_stage. Each
// instruction carries a planned ack delay; expected outputs for every cycle are
// derived from that delay and the timeout rule, with a word-addressed memory
// model supplying load data.
// -----------------------------------------------------------------------------
module tb_memory_stage;
    localparam int unsigned TMO      = 4;
    localparam int          NEVER    = 1000;
    localparam logic [1:0]  SRC_DATA = 2'd0;
    localparam logic [1:0]  SRC_NOP  = 2'd1;
    localparam logic [1:0]  SRC_EXC  = 2'd2;
    localparam logic [31:0] NOP_I    = 32'h83FF_F800;
    localparam logic [31:0] BNE_X    = 32'h77DF_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] y;
        logic [31:0] st;
        logic [1:0]  src;
        int          d;
    } ins_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  ir_src_mem;
    logic [31:0] pc_mem_next, ir_mem_next, y_mem_next, st_mem_next;
    logic        stall_mem, mem_fault;
    logic [31:0] pc_wb_next, ir_wb_next, y_wb_next, ld_wb_next;

    memory_stage_if dmem_bus();

    memory_stage #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .ir_src_mem  (ir_src_mem),
        .pc_mem_next (pc_mem_next),
        .ir_mem_next (ir_mem_next),
        .y_mem_next  (y_mem_next),
        .st_mem_next (st_mem_next),
        .dmem        (dmem_bus),
        .stall_mem   (stall_mem),
        .mem_fault   (mem_fault),
        .pc_wb_next  (pc_wb_next),
        .ir_wb_next  (ir_wb_next),
        .y_wb_next   (y_wb_next),
        .ld_wb_next  (ld_wb_next)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    ins_t        cur, nxt;
    int          k;
    int          idx;
    logic [31:0] mem_m [logic [31:0]];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic ins_t gen_ins(input int i);
        ins_t t;
        int   r;
        t.pc  = 32'h0000_1000 + 32'(i) * 32'd4;
        t.st  = $urandom;
        t.src = SRC_DATA;
        case (i)
            0: begin t.ir = {6'h18, 5'd1, 5'd31, 16'h0104}; t.y = 32'h104; t.d = 0; end
            1: begin t.ir = {6'h19, 5'd2, 5'd31, 16'h0020}; t.y = 32'h20; t.st = 32'h1234_5678; t.d = 3; end
            2: begin t.ir = {6'h20, 26'h0443}; t.y = $urandom; t.d = 0; end
            3: begin t.ir = {6'h18, 26'h0}; t.y = 32'h40; t.src = SRC_NOP; t.d = 0; end
            4: begin t.ir = {6'h18, 26'h1}; t.y = 32'h44; t.d = NEVER; end
            5: begin t.ir = {6'h1F, 26'h2}; t.y = 32'h48; t.d = int'(TMO); end
            6: begin t.ir = {6'h18, 26'h3}; t.y = 32'h23; t.d = 1; end
            default: begin
                r = $urandom_range(0, 5);
                case (r)
                    0: t.ir = {6'h18, 26'($urandom)};
                    1: t.ir = {6'h19, 26'($urandom)};
                    2: t.ir = {6'h1F, 26'($urandom)};
                    3: t.ir = {6'h20, 26'($urandom)};
                    4: t.ir = {6'h1D, 26'($urandom)};
                    default: t.ir = $urandom;
                endcase
                t.y = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 127));
                r = $urandom_range(0, 9);
                t.src = (r == 0) ? SRC_NOP : (r == 1) ? SRC_EXC : SRC_DATA;
                r = $urandom_range(0, 9);
                if (r == 0)      t.d = NEVER;
                else if (r == 1) t.d = int'(TMO);
                else if (r == 2) t.d = int'(TMO) - 1;
                else             t.d = $urandom_range(0, 2);
            end
        endcase
        return t;
    endfunction

    // One clock cycle; entered and left 1 time unit after a rising edge.
    task automatic run_cycle();
        logic [5:0]  op;
        logic        memop, ld, ack;
        logic        e_req, e_stall, e_fault, e_done;
        logic [31:0] e_ir, e_ld, addr, rd;
        op      = cur.ir[31:26];
        memop   = (cur.src == SRC_DATA) && (op == 6'h18 || op == 6'h19 || op == 6'h1F);
        ld      = (op != 6'h19);
        addr    = {cur.y[31:2], 2'b00};
        e_req   = 1'b0;
        e_stall = 1'b0;
        e_fault = 1'b0;
        e_done  = 1'b0;
        if (memop) begin
            if (cur.d < int'(TMO)) begin
                e_req   = 1'b1;
                e_stall = (k < cur.d);
                e_done  = (k == cur.d);
            end else begin
                e_req   = (k < int'(TMO));
                e_stall = e_req;
                e_fault = (k == int'(TMO));
            end
            ack = (k == cur.d);
        end else begin
            ack = 1'($urandom_range(0, 1));
        end
        rd = $urandom;
        if (e_done && ld) begin
            if (!mem_m.exists(addr)) mem_m[addr] = $urandom;
            rd = mem_m[addr];
        end
        e_ld = (e_done && ld) ? rd : 32'd0;
        if (cur.src == SRC_EXC || e_fault)      e_ir = BNE_X;
        else if (cur.src == SRC_NOP || e_stall) e_ir = NOP_I;
        else                                    e_ir = cur.ir;

        ir_src_mem          = cur.src;
        dmem_bus.dmem_ack   = ack;
        dmem_bus.dmem_rdata = rd;
        if (e_stall) begin
            // upstream is frozen: anything presented now must be ignored
            pc_mem_next = $urandom;
            ir_mem_next = $urandom;
            y_mem_next  = $urandom;
            st_mem_next = $urandom;
        end else begin
            pc_mem_next = nxt.pc;
            ir_mem_next = nxt.ir;
            y_mem_next  = nxt.y;
            st_mem_next = nxt.st;
        end
        #3;
        check_eq("req",   32'(dmem_bus.dmem_req), 32'(e_req));
        check_eq("stall", 32'(stall_mem),         32'(e_stall));
        check_eq("fault", 32'(mem_fault),         32'(e_fault));
        check_eq("ir_wb", ir_wb_next, e_ir);
        check_eq("pc_wb", pc_wb_next, cur.pc);
        check_eq("y_wb",  y_wb_next,  cur.y);
        check_eq("ld_wb", ld_wb_next, e_ld);
        if (e_req) begin
            check_eq("we",    32'(dmem_bus.dmem_we), 32'(!ld));
            check_eq("addr",  dmem_bus.dmem_addr,    addr);
            check_eq("wdata", dmem_bus.dmem_wdata,   cur.st);
        end
        if (e_done && !ld) mem_m[addr] = cur.st;
        @(posedge clk);
        #1;
        if (e_stall) begin
            k++;
        end else begin
            cur = nxt;
            idx++;
            nxt = gen_ins(idx);
            k   = 0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ins_t rst_ld;
        logic reached;
        ins_t idle_i;

        idle_i = '{32'h0, NOP_I, 32'h0, 32'h0, SRC_DATA, 0};
        rst = 1'b1;
        ir_src_mem = SRC_DATA;
        pc_mem_next = '0;
        ir_mem_next = '0;
        y_mem_next  = '0;
        st_mem_next = '0;
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = '0;
        mem_m[32'h104] = 32'hDEAD_BEEF;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req",   32'(dmem_bus.dmem_req), 32'd0);
        check_eq("rst_stall", 32'(stall_mem),         32'd0);
        check_eq("rst_fault", 32'(mem_fault),         32'd0);
        check_eq("rst_ir_wb", ir_wb_next, NOP_I);
        check_eq("rst_pc_wb", pc_wb_next, 32'd0);
        check_eq("rst_y_wb",  y_wb_next,  32'd0);

        cur = idle_i;
        idx = 0;
        nxt = gen_ins(0);
        k   = 0;
        rst = 1'b0;
        repeat (400) run_cycle();

        // Reset while an access is outstanding
        rst_ld  = '{32'hCAFE_0000, {6'h18, 26'h5}, 32'h60, 32'h0, SRC_DATA, NEVER};
        nxt     = rst_ld;
        reached = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (cur.pc == rst_ld.pc && k == 2) begin
                reached = 1'b1;
                break;
            end
            run_cycle();
        end
        check_eq("t6_reach", 32'(reached), 32'd1);
        ir_src_mem        = SRC_DATA;
        dmem_bus.dmem_ack = 1'b0;
        #1;
        check_eq("t6_req_before", 32'(dmem_bus.dmem_req), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("t6_req",   32'(dmem_bus.dmem_req), 32'd0);
        check_eq("t6_stall", 32'(stall_mem),         32'd0);
        check_eq("t6_fault", 32'(mem_fault),         32'd0);
        check_eq("t6_ir_wb", ir_wb_next, NOP_I);
        @(posedge clk);
        #1;
        check_eq("t6_req_held", 32'(dmem_bus.dmem_req), 32'd0);
        rst = 1'b0;
        cur = idle_i;
        k   = 0;
        nxt = '{32'hCAFE_0004, {6'h18, 26'h6}, 32'h104, 32'h0, SRC_DATA, 1};
        repeat (300) run_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
